float_classify_stage: RTL
=========================

Name: float_classify_stage

Overview:
- Registered input stage directly upstream of the normalized float-to-fixed converter.
- Accepts IEEE-style floats plus a radix point over a valid/ready handshake and classifies each word as zero, denormal, normal, infinity or NaN.
- Presents the word with registered InNormal/InZero-style flags to the converter.
- A two-entry skid buffer gives full throughput and cuts the ready path combinationally.

Parameters:
- FLOATSIZE, 32, total float width.
- EXPONENTBITS, 8, exponent field width.
- MANTISSABITS, 23, mantissa field width; FLOATSIZE = 1+EXPONENTBITS+MANTISSABITS.
- RADIXPOINTSIZE, 6, width of the radix point field.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-high.
- InValid  in  1  upstream word valid.
- InReady  out  1  stage can accept a word.
- InFloat  in  FLOATSIZE  float word.
- InRadixPoint  in  RADIXPOINTSIZE  radix point position from right, travels with the word.
- OutValid  out  1  output word valid.
- OutReady  in  1  downstream accepts.
- OutFloat  out  FLOATSIZE  registered float word.
- OutRadixPoint  out  RADIXPOINTSIZE  registered radix point.
- OutNormal  out  1  hidden bit: 1 normal, 0 denormal/zero/special.
- OutZero  out  1  word is ±0 (forces converter output to 0).
- OutInf  out  1  exponent all ones, mantissa zero.
- OutNaN  out  1  exponent all ones, mantissa nonzero.

Behaviour:
- Reset (Rst high at a Clk edge): OutValid=0, all data/flag outputs 0, skid entry empty, InReady=0 while Rst is high and 1 on the first cycle after.
- Transfer rules:
  - Input transfer occurs when InValid&InReady at an edge.
  - Output transfer occurs when OutValid&OutReady.
  - OutValid and all output data are held stable until the output transfer completes.
- Classification (combinational on InFloat, registered with the word), E=exponent field, M=mantissa field:
  - E==0, M==0 -> OutZero=1, OutNormal=0.
  - E==0, M!=0 -> denormal, OutNormal=0, OutZero=0.
  - E all ones, M==0 -> OutInf=1, OutNormal=0.
  - E all ones, M!=0 -> OutNaN=1, OutNormal=0.
  - Otherwise -> OutNormal=1.
  - Exactly one of {normal, denormal, zero, inf, nan} holds per word. Sign does not affect the class.
- Latency: 1 cycle from input transfer to OutValid when the output register is empty or draining.
- Skid buffer:
  - Two entries: the output register and one skid register.
  - InReady = ~skid_full (registered).
  - Accepting a word while the output register is full and OutReady=0 places it in the skid register. InReady then drops next cycle.
  - On an output transfer with the skid register full, the skid entry moves to the output register and InReady rises next cycle.
- Simultaneous input and output transfer with skid empty: the new word replaces the output register; OutValid stays 1.
- Ordering: words leave strictly in acceptance order; no drop or duplication under any OutReady pattern.
- Throughput: one word per cycle when OutReady is held high.
- Reset mid-operation: both entries are discarded; there is no partial output.
- OutFloat is passed through bit-exact; classification never alters data.

Optional Feature:
- FLOAT_CLASSIFY_FTZ_EN defined: denormals are flushed, i.e. E==0 with M!=0 gives OutZero=1, OutNormal=0, and OutFloat mantissa bits are forced to 0 (sign kept).
- Undefined: denormals pass as described above with OutZero=0.

Decomposition:
- Package float_fixed_pkg:
  - Default widths (FLOATSIZE, EXPONENTBITS, MANTISSABITS, RADIXPOINTSIZE).
  - Class encoding constants (CLS_ZERO, CLS_DENORM, CLS_NORMAL, CLS_INF, CLS_NAN).
  - Function computing the all-ones exponent.
- One natural sub-module, float_classifier: purely combinational, taking InFloat to the class flags. The skid/handshake logic stays in the top module.

Test Plan:
- Classification, OutReady=1: send 0x3F800000, 0x00000000, 0x80000001, 0x7F800000, 0x7FC00000.
  - Required flags, one cycle later each: Normal; Zero; denormal (Normal=0, Zero=0); Inf; NaN.
  - OutFloat is bit-exact for every word.
- Throughput: 8 back-to-back words with OutReady=1 and InRadixPoint=16. OutValid is high for 8 consecutive cycles, same order, OutRadixPoint=16 each.
- Backpressure: OutReady=0, send words A, B, C.
  - A and B are accepted; InReady=0 afterwards; C is held by the source.
  - Raise OutReady: A, B, C emerge in order with no loss.
- Simultaneous transfer: skid empty, OutValid=1, input and output transfer in the same cycle. New word appears next cycle with no OutValid bubble.
- Reset mid-stream: assert Rst with both entries full. Next cycle OutValid=0 and all outputs 0; InReady=1 the cycle after Rst drops.
- FLOAT_CLASSIFY_FTZ_EN defined: 0x80000001 gives OutZero=1 and OutFloat=0x80000000.

Source files
------------

// File: rtl/float_fixed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_fixed_pkg
// Description : Shared definitions for the float-to-fixed front end.
//               Holds the default float/radix-point widths, the float class
//               encoding and a helper that builds an all-ones exponent.
// Revision    : 1.0 - initial release
// ============================================================================
package float_fixed_pkg;

  localparam int DEF_FLOATSIZE      = 32;
  localparam int DEF_EXPONENTBITS   = 8;
  localparam int DEF_MANTISSABITS   = 23;
  localparam int DEF_RADIXPOINTSIZE = 6;

  // Exactly one class applies to each float word.
  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } float_class_e;

  // All-ones exponent pattern for an exponent field of the given width.
  // The caller truncates the result to its own exponent width.
  function automatic logic [31:0] exp_all_ones(input int bits);
    logic [63:0] ones;
    ones = (64'd1 << bits) - 64'd1;
    return ones[31:0];
  endfunction

endpackage : float_fixed_pkg
`default_nettype wire

// File: rtl/float_classifier.sv
`default_nettype none
// ============================================================================
// Module      : float_classifier
// Description : Purely combinational classifier for one IEEE-style float.
//               Decodes exponent/mantissa into zero, denormal, normal,
//               infinity or NaN flags (sign never affects the class).
//               Optional macro FLOAT_CLASSIFY_FTZ_EN flushes denormals to
//               signed zero (class zero, mantissa bits cleared).
// Ports       : float_i  - float word in
//               float_o  - float word out (bit-exact unless flushed)
//               normal_o - hidden bit (1 only for normal numbers)
//               zero_o   - word is +/-0 (or a flushed denormal)
//               inf_o    - exponent all ones, mantissa zero
//               nan_o    - exponent all ones, mantissa nonzero
// Revision    : 1.0 - initial release
// ============================================================================
module float_classifier
  import float_fixed_pkg::*;
#(
  parameter int EXPONENTBITS = DEF_EXPONENTBITS,
  parameter int MANTISSABITS = DEF_MANTISSABITS,
  parameter int FLOATSIZE    = 1 + EXPONENTBITS + MANTISSABITS
) (
  input  logic [FLOATSIZE-1:0] float_i,
  output logic [FLOATSIZE-1:0] float_o,
  output logic                 normal_o,
  output logic                 zero_o,
  output logic                 inf_o,
  output logic                 nan_o
);

  localparam logic [31:0]             C_ONES32  = exp_all_ones(EXPONENTBITS);
  localparam logic [EXPONENTBITS-1:0] C_EXP_MAX = C_ONES32[EXPONENTBITS-1:0];

  logic [EXPONENTBITS-1:0] w_exp;
  logic [MANTISSABITS-1:0] w_man;
  float_class_e            w_cls;

  assign w_exp = float_i[FLOATSIZE-2 -: EXPONENTBITS];
  assign w_man = float_i[MANTISSABITS-1:0];

  always_comb begin
    w_cls   = CLS_NORMAL;
    float_o = float_i;
    if (w_exp == '0) begin
      if (w_man == '0) begin
        w_cls = CLS_ZERO;
      end else begin
`ifdef FLOAT_CLASSIFY_FTZ_EN
        // Flush to zero: keep sign and exponent (already zero), drop mantissa.
        w_cls                      = CLS_ZERO;
        float_o[MANTISSABITS-1:0]  = '0;
`else
        w_cls = CLS_DENORM;
`endif
      end
    end else if (w_exp == C_EXP_MAX) begin
      w_cls = (w_man == '0) ? CLS_INF : CLS_NAN;
    end
  end

  assign normal_o = (w_cls == CLS_NORMAL);
  assign zero_o   = (w_cls == CLS_ZERO);
  assign inf_o    = (w_cls == CLS_INF);
  assign nan_o    = (w_cls == CLS_NAN);

endmodule : float_classifier
`default_nettype wire

// File: rtl/float_classify_stage.sv
`default_nettype none
// ============================================================================
// Module      : float_classify_stage
// Description : Registered input stage ahead of the float-to-fixed converter.
//               Classifies each float, registers word + radix point + flags,
//               and uses a two-entry skid buffer (output register + one skid
//               register) so InReady is a pure register output while still
//               sustaining one word per cycle.
//               Optional macro FLOAT_CLASSIFY_FTZ_EN: flush denormals to zero.
// Ports       : Clk, Rst (sync, active-high)
//               InValid/InReady/InFloat/InRadixPoint   - upstream handshake
//               OutValid/OutReady/OutFloat/OutRadixPoint - downstream handshake
//               OutNormal/OutZero/OutInf/OutNaN        - registered class flags
// Revision    : 1.0 - initial release
// ============================================================================
module float_classify_stage
  import float_fixed_pkg::*;
#(
  parameter int FLOATSIZE      = DEF_FLOATSIZE,
  parameter int EXPONENTBITS   = DEF_EXPONENTBITS,
  parameter int MANTISSABITS   = DEF_MANTISSABITS,
  parameter int RADIXPOINTSIZE = DEF_RADIXPOINTSIZE
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [FLOATSIZE-1:0]      InFloat,
  input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [FLOATSIZE-1:0]      OutFloat,
  output logic [RADIXPOINTSIZE-1:0] OutRadixPoint,
  output logic                      OutNormal,
  output logic                      OutZero,
  output logic                      OutInf,
  output logic                      OutNaN
);

  typedef struct packed {
    logic [FLOATSIZE-1:0]      flt;
    logic [RADIXPOINTSIZE-1:0] radix;
    logic                      normal;
    logic                      zero;
    logic                      inf;
    logic                      nan;
  } word_t;

  word_t w_in_word;
  word_t out_word_q, out_word_d;
  word_t skid_word_q, skid_word_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q, ready_d;
  logic  w_in_xfer;
  logic  w_out_xfer;

  float_classifier #(
    .EXPONENTBITS (EXPONENTBITS),
    .MANTISSABITS (MANTISSABITS),
    .FLOATSIZE    (FLOATSIZE)
  ) u_classifier (
    .float_i  (InFloat),
    .float_o  (w_in_word.flt),
    .normal_o (w_in_word.normal),
    .zero_o   (w_in_word.zero),
    .inf_o    (w_in_word.inf),
    .nan_o    (w_in_word.nan)
  );

  assign w_in_word.radix = InRadixPoint;

  assign w_in_xfer  = InValid & ready_q;
  assign w_out_xfer = out_valid_q & OutReady;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    if (skid_valid_q) begin
      // InReady is low here, so only a drain into the output register occurs.
      if (w_out_xfer) begin
        out_word_d   = skid_word_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || w_out_xfer) begin
      // Output register free or emptying this cycle: new word goes straight in.
      out_valid_d = w_in_xfer;
      if (w_in_xfer) begin
        out_word_d = w_in_word;
      end
    end else if (w_in_xfer) begin
      // Output stalled: park the accepted word in the skid register.
      skid_valid_d = 1'b1;
      skid_word_d  = w_in_word;
    end
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      ready_q      <= ready_d;
    end
  end

  assign InReady       = ready_q;
  assign OutValid      = out_valid_q;
  assign OutFloat      = out_word_q.flt;
  assign OutRadixPoint = out_word_q.radix;
  assign OutNormal     = out_word_q.normal;
  assign OutZero       = out_word_q.zero;
  assign OutInf        = out_word_q.inf;
  assign OutNaN        = out_word_q.nan;

endmodule : float_classify_stage
`default_nettype wire
